// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MIPS data memory: access-size encodings,
// RAM geometry and memory-mapped register addresses.
package mips_mem_pkg;

  typedef enum logic [1:0] {
    MODE_WORD  = 2'b00,
    MODE_HALF  = 2'b01,
    MODE_BYTE  = 2'b10,
    MODE_UBYTE = 2'b11
  } mem_mode_e;

  localparam int          RAM_DEPTH    = 8192;
  localparam int          RAM_AW       = 13;
  localparam logic [15:0] RAM_BASE     = 16'h0000;
  localparam logic [15:0] RAM_LIMIT    = 16'h7FFF;

  localparam logic [15:0] MMIO_BASE    = 16'hFF00;
  localparam logic [15:0] ADDR_COUNTER = 16'hFF00;
  localparam logic [15:0] ADDR_IO      = 16'hFF04;
  localparam logic [15:0] ADDR_STATUS  = 16'hFF08;

  // Big-endian byte enables: lane 3 is bits 31:24 and sits at addr[1:0]=0.
  function automatic logic [3:0] byte_enables(mem_mode_e mode, logic [1:0] lsb);
    logic [3:0] be;
    case (mode)
      MODE_WORD: be = 4'b1111;
      MODE_HALF: be = lsb[1] ? 4'b0011 : 4'b1100;
      default:   be = 4'b1000 >> lsb;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/mips_mem_ram.sv
// 8192x32 data RAM with per-byte write enables and asynchronous read.
// Contents are never reset.
module mips_mem_ram
  import mips_mem_pkg::*;
(
  input  logic              clk,
  input  logic [3:0]        we,
  input  logic [RAM_AW-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [0:RAM_DEPTH-1];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/mips_data_memory.sv
// MIPS data memory: RAM plus cycle counter, output port and fault status
// registers, with big-endian sub-word access and load extension.
module mips_data_memory
  import mips_mem_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [1:0]  MemMode,
  input  logic [15:0] memAddr,
  input  logic [31:0] writeMemData,
  output logic [31:0] memData,
  output logic [31:0] ioOut,
  output logic        memFault
);

  mem_mode_e   mode;
  logic        is_ram;
  logic        is_mmio;
  logic        misaligned;
  logic        store_ok;
  logic [3:0]  ram_we;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic [31:0] raw_word;
  logic [15:0] half_sel;
  logic [7:0]  byte_sel;
  logic [31:0] cycle_cnt;
  logic [31:0] io_reg;
  logic        fault;

  assign mode    = mem_mode_e'(MemMode);
  assign is_ram  = (memAddr <= RAM_LIMIT);
  assign is_mmio = (memAddr[15:4] == MMIO_BASE[15:4]);

  assign misaligned = ((mode == MODE_WORD) && (memAddr[1:0] != 2'b00)) ||
                      ((mode == MODE_HALF) && memAddr[0]);
  assign store_ok   = MemWrite && !reset && !misaligned;

  always_comb begin
    ram_wdata = writeMemData;
    case (mode)
      MODE_WORD: ram_wdata = writeMemData;
      MODE_HALF: ram_wdata = {2{writeMemData[15:0]}};
      default:   ram_wdata = {4{writeMemData[7:0]}};
    endcase
  end

  assign ram_we = (store_ok && is_ram) ? byte_enables(mode, memAddr[1:0]) : 4'b0000;

  mips_mem_ram u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (memAddr[RAM_AW+1:2]),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // Read path: select the aligned word, then the lane, then extend.
  always_comb begin
    raw_word = 32'h0;
    if (is_ram) begin
      raw_word = ram_rdata;
    end else if (is_mmio) begin
      case (memAddr[3:2])
        2'd0:    raw_word = cycle_cnt;
        2'd1:    raw_word = io_reg;
        2'd2:    raw_word = {31'h0, fault};
        default: raw_word = 32'h0;
      endcase
    end
  end

  always_comb begin
    half_sel = memAddr[1] ? raw_word[15:0] : raw_word[31:16];
    case (memAddr[1:0])
      2'd0:    byte_sel = raw_word[31:24];
      2'd1:    byte_sel = raw_word[23:16];
      2'd2:    byte_sel = raw_word[15:8];
      default: byte_sel = raw_word[7:0];
    endcase
  end

  always_comb begin
    case (mode)
      MODE_WORD: memData = raw_word;
      MODE_HALF: memData = {{16{half_sel[15]}}, half_sel};
      MODE_BYTE: memData = {{24{byte_sel[7]}}, byte_sel};
      default:   memData = {24'h0, byte_sel};
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_cnt <= 32'h0;
      io_reg    <= 32'h0;
      fault     <= 1'b0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      if (store_ok && (memAddr == ADDR_IO) && (mode == MODE_WORD))
        io_reg <= writeMemData;
      if (MemWrite && misaligned)
        fault <= 1'b1;
      else if (store_ok && (memAddr == ADDR_STATUS) && (mode == MODE_WORD) && writeMemData[0])
        fault <= 1'b0;
    end
  end

  assign ioOut    = io_reg;
  assign memFault = fault;

endmodule

// File: tb/tb_mips_data_memory.sv
// Directed self-checking bench for mips_data_memory.
module tb_mips_data_memory;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemWrite;
  logic [1:0]  MemMode;
  logic [15:0] memAddr;
  logic [31:0] writeMemData;
  logic [31:0] memData;
  logic [31:0] ioOut;
  logic        memFault;

  int checks = 0;
  int fails  = 0;

  localparam logic [1:0] W = 2'b00, H = 2'b01, B = 2'b10, BU = 2'b11;

  mips_data_memory dut (
    .clk          (clk),
    .reset        (reset),
    .MemWrite     (MemWrite),
    .MemMode      (MemMode),
    .memAddr      (memAddr),
    .writeMemData (writeMemData),
    .memData      (memData),
    .ioOut        (ioOut),
    .memFault     (memFault)
  );

  always #5 clk = ~clk;

  task automatic do_store(input logic [15:0] a, input logic [1:0] m, input logic [31:0] d);
    @(negedge clk);
    memAddr = a; MemMode = m; writeMemData = d; MemWrite = 1'b1;
    @(posedge clk);
    #1;
    MemWrite = 1'b0;
  endtask

  task automatic set_read(input logic [15:0] a, input logic [1:0] m);
    memAddr = a; MemMode = m;
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; MemWrite = 1'b0; MemMode = W; memAddr = 16'h0; writeMemData = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (memFault !== 1'b0) begin fails++; $display("FAIL reset_fault got %0b exp 0", memFault); end
    checks++; if (ioOut !== 32'h0) begin fails++; $display("FAIL reset_io got %h exp 00000000", ioOut); end
    set_read(16'hFF00, W);
    checks++; if (memData !== 32'h0) begin fails++; $display("FAIL reset_counter got %h exp 00000000", memData); end
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_word_store_bytes;
    logic [31:0] exp_b [4];
    exp_b[0] = 32'h12; exp_b[1] = 32'h34; exp_b[2] = 32'h56; exp_b[3] = 32'h78;
    do_store(16'h0010, W, 32'h12345678);
    for (int i = 0; i < 4; i++) begin
      set_read(16'h0010 + 16'(i), B);
      checks++; if (memData !== exp_b[i]) begin fails++; $display("FAIL byte_read[%0d] got %h exp %h", i, memData, exp_b[i]); end
    end
    set_read(16'h0012, H);
    checks++; if (memData !== 32'h00005678) begin fails++; $display("FAIL half_read got %h exp 00005678", memData); end
    set_read(16'h0010, H);
    checks++; if (memData !== 32'h00001234) begin fails++; $display("FAIL half_read_hi got %h exp 00001234", memData); end
  endtask

  task automatic test_byte_store;
    do_store(16'h0020, W, 32'h0);
    do_store(16'h0021, B, 32'h000000AB);
    set_read(16'h0020, W);
    checks++; if (memData !== 32'h00AB0000) begin fails++; $display("FAIL byte_store_word got %h exp 00AB0000", memData); end
    set_read(16'h0021, B);
    checks++; if (memData !== 32'hFFFFFFAB) begin fails++; $display("FAIL byte_signed got %h exp FFFFFFAB", memData); end
    set_read(16'h0021, BU);
    checks++; if (memData !== 32'h000000AB) begin fails++; $display("FAIL byte_unsigned got %h exp 000000AB", memData); end
    do_store(16'h0022, H, 32'h1234BEEF);
    set_read(16'h0023, W);
    checks++; if (memData !== 32'h00ABBEEF) begin fails++; $display("FAIL half_store_word got %h exp 00ABBEEF", memData); end
    set_read(16'h0023, H);
    checks++; if (memData !== 32'hFFFFBEEF) begin fails++; $display("FAIL half_signed_misaligned got %h exp FFFFBEEF", memData); end
    checks++; if (memFault !== 1'b0) begin fails++; $display("FAIL read_no_fault got %0b exp 0", memFault); end
  endtask

  task automatic test_read_during_write;
    do_store(16'h0050, W, 32'hAAAA5555);
    @(negedge clk);
    memAddr = 16'h0050; MemMode = W; writeMemData = 32'h000055AA; MemWrite = 1'b1;
    #1;
    checks++; if (memData !== 32'hAAAA5555) begin fails++; $display("FAIL rdw_old got %h exp AAAA5555", memData); end
    @(posedge clk);
    #1;
    MemWrite = 1'b0;
    #1;
    checks++; if (memData !== 32'h000055AA) begin fails++; $display("FAIL rdw_new got %h exp 000055AA", memData); end
  endtask

  task automatic test_fault;
    do_store(16'h0040, W, 32'h11111111);
    do_store(16'h0042, W, 32'hDEADBEEF);
    checks++; if (memFault !== 1'b1) begin fails++; $display("FAIL fault_set got %0b exp 1", memFault); end
    set_read(16'h0040, W);
    checks++; if (memData !== 32'h11111111) begin fails++; $display("FAIL fault_suppressed got %h exp 11111111", memData); end
    set_read(16'hFF08, W);
    checks++; if (memData !== 32'h00000001) begin fails++; $display("FAIL status_read got %h exp 00000001", memData); end
    do_store(16'hFF08, W, 32'h0);
    checks++; if (memFault !== 1'b1) begin fails++; $display("FAIL fault_hold got %0b exp 1", memFault); end
    do_store(16'hFF08, W, 32'h1);
    checks++; if (memFault !== 1'b0) begin fails++; $display("FAIL fault_clear got %0b exp 0", memFault); end
    do_store(16'h0041, H, 32'h0000FFFF);
    checks++; if (memFault !== 1'b1) begin fails++; $display("FAIL half_fault got %0b exp 1", memFault); end
    set_read(16'h0040, W);
    checks++; if (memData !== 32'h11111111) begin fails++; $display("FAIL half_suppressed got %h exp 11111111", memData); end
    do_store(16'hFF08, W, 32'h1);
    checks++; if (memFault !== 1'b0) begin fails++; $display("FAIL fault_clear2 got %0b exp 0", memFault); end
  endtask

  task automatic test_counter;
    @(negedge clk);
    reset = 1'b1; memAddr = 16'hFF00; MemMode = W;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checks++; if (memData !== 32'd5) begin fails++; $display("FAIL counter_5 got %0d exp 5", memData); end
    do_store(16'hFF00, W, 32'h12345678);
    checks++; if (memData !== 32'd6) begin fails++; $display("FAIL counter_ro got %0d exp 6", memData); end
    @(negedge clk);
    force dut.cycle_cnt = 32'hFFFFFFFF;
    #1;
    checks++; if (memData !== 32'hFFFFFFFF) begin fails++; $display("FAIL counter_max got %h exp FFFFFFFF", memData); end
    release dut.cycle_cnt;
    @(posedge clk);
    #1;
    checks++; if (memData !== 32'h0) begin fails++; $display("FAIL counter_wrap got %h exp 00000000", memData); end
  endtask

  task automatic test_io;
    do_store(16'hFF04, W, 32'h000000A5);
    checks++; if (ioOut !== 32'h000000A5) begin fails++; $display("FAIL io_write got %h exp 000000A5", ioOut); end
    do_store(16'hFF07, B, 32'h0000003C);
    checks++; if (ioOut !== 32'h000000A5) begin fails++; $display("FAIL io_byte_ignored got %h exp 000000A5", ioOut); end
    checks++; if (memFault !== 1'b0) begin fails++; $display("FAIL io_byte_nofault got %0b exp 0", memFault); end
    set_read(16'hFF07, BU);
    checks++; if (memData !== 32'h000000A5) begin fails++; $display("FAIL io_byte_read got %h exp 000000A5", memData); end
    set_read(16'hFF07, B);
    checks++; if (memData !== 32'hFFFFFFA5) begin fails++; $display("FAIL io_sbyte_read got %h exp FFFFFFA5", memData); end
    do_store(16'h8000, W, 32'h55555555);
    set_read(16'h8000, W);
    checks++; if (memData !== 32'h0) begin fails++; $display("FAIL unmapped_read got %h exp 00000000", memData); end
    set_read(16'hFF0C, W);
    checks++; if (memData !== 32'h0) begin fails++; $display("FAIL mmio_hole got %h exp 00000000", memData); end
    checks++; if (memFault !== 1'b0) begin fails++; $display("FAIL unmapped_nofault got %0b exp 0", memFault); end
    // Store during reset must not land; registers return to reset values.
    @(negedge clk);
    reset = 1'b1; memAddr = 16'h0010; MemMode = W; writeMemData = 32'hCAFEF00D; MemWrite = 1'b1;
    @(posedge clk);
    #1;
    MemWrite = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++; if (ioOut !== 32'h0) begin fails++; $display("FAIL io_reset got %h exp 00000000", ioOut); end
    set_read(16'h0010, W);
    checks++; if (memData !== 32'h12345678) begin fails++; $display("FAIL ram_kept got %h exp 12345678", memData); end
  endtask

  initial begin
    test_reset;
    test_word_store_bytes;
    test_byte_store;
    test_read_during_write;
    test_fault;
    test_counter;
    test_io;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running exp finished");
    $fatal(1);
  end

endmodule

// File: doc/mips_data_memory.md
MIPS_DATA_MEMORY -- requirements
Module: mips_data_memory

Interface
REQ-001 The block SHALL have these ports, one per line:
  clk  input  1  single system clock; all state updates on rising edge
  reset  input  1  synchronous, active-high reset
  MemWrite  input  1  store strobe from CPU; write committed at rising edge
  MemMode  input  2  access size: 00 word, 01 half signed, 10 byte signed, 11 byte unsigned
  memAddr  input  16  byte address from CPU
  writeMemData  input  32  store data from CPU, right-justified for half/byte
  memData  output  32  load data to CPU, extended per MemMode
  ioOut  output  32  memory-mapped output port register
  memFault  output  1  sticky misaligned-store flag
REQ-002 Reset SHALL be synchronous and active-high on port reset, sampled on the rising edge of clk, the single clock.

Function
REQ-003 Address map SHALL be: RAM 0x0000-0x7FFF (8192 words); MMIO 0xFF00-0xFF0F; all other addresses unmapped.
REQ-004 Byte order SHALL be big-endian: addr[1:0]=0 selects bits 31:24, =3 selects bits 7:0; a half at addr[1]=0 selects bits 31:16.
REQ-005 Reads SHALL be combinational: memData reflects current memAddr/MemMode and array contents in the same cycle, zero latency.
REQ-006 Load extension: half signed and byte signed SHALL sign-extend to 32 bits; byte unsigned SHALL zero-extend; word returns unmodified.
REQ-007 Reads SHALL ignore misalignment: word reads force addr[1:0]=0, half reads force addr[0]=0; no fault is raised on reads.
REQ-008 Stores SHALL update only the addressed byte lanes (byte enables) at the rising edge where MemWrite=1; other lanes are unchanged.
REQ-009 A store with word mode and addr[1:0]!=0, or half mode and addr[0]!=0, SHALL be suppressed and SHALL set memFault on that edge.
REQ-010 A read in the cycle of a store to the same address SHALL return pre-write data; new data is visible from the next cycle.
REQ-011 MMIO 0xFF00: 32-bit free-running cycle counter, read-only, +1 every cycle, wraps 0xFFFFFFFF->0; reads return the pre-increment value; stores are ignored.
REQ-012 MMIO 0xFF04: ioOut register, word stores only (half/byte stores ignored, no fault); readable; ioOut drives the port directly.
REQ-013 MMIO 0xFF08: status; bit0 = memFault, other bits read 0; a word store with bit0=1 clears memFault.
REQ-014 Sub-word reads of MMIO SHALL use the same lane selection and extension as RAM.
REQ-015 Unmapped reads SHALL return 0; unmapped stores SHALL be ignored without fault, unless misaligned (REQ-009 applies everywhere).

Reset
REQ-016 Under reset: counter=0, ioOut=0, memFault=0; RAM contents SHALL NOT be cleared (optional hex preload at elaboration).
REQ-017 A store asserted in a reset cycle SHALL be suppressed; reset mid-program restores the values in REQ-016 on the next edge.

Structure
REQ-018 Shared package mips_mem_pkg SHALL hold the MemMode encodings, RAM depth/address range and MMIO addresses.
REQ-019 RAM array SHALL be a sub-module mips_mem_ram (8192x32, 4 byte-write enables, async read); decode, alignment, extension and MMIO stay in the top.

Verification
REQ-020 Word store 0x12345678 to 0x0010, then byte-signed reads 0x0010..0x0013 -> 0x00000012, 0x00000034, 0x00000056, 0x00000078; half read 0x0012 -> 0x00005678.
REQ-021 Byte store 0xAB to 0x0021 over word 0x00000000 -> word read 0x0020 = 0x00AB0000; byte-signed read 0x0021 = 0xFFFFFFAB; byte-unsigned = 0x000000AB.
REQ-022 Word store 0xDEADBEEF to 0x0042 -> memFault=1 next cycle, word at 0x0040 unchanged; word store 0x1 to 0xFF08 -> memFault=0.
REQ-023 Release reset, read 0xFF00 at 5 cycles after reset deassert -> 5; force counter 0xFFFFFFFF -> next cycle reads 0.
REQ-024 Word store 0x000000A5 to 0xFF04 -> ioOut=0x000000A5 next cycle; byte store to 0xFF07 -> ioOut unchanged; assert reset -> ioOut=0, RAM word at 0x0010 still 0x12345678.
